sdram_test_seq: RTL and testbench
=================================

Name: sdram_test_seq

Overview:
- Upstream traffic generator and checker for the Apple II SDRAM controller.
- Issues one byte access per clkref period on the controller's addr/din/we/aux inputs, sweeping the whole address space.
- Runs four write-then-readback data passes and checks each read byte against the expected pattern.
- Reports pass/fail, error count and the first failing location to the tester front-end.

Parameters:
- ADDR_BITS, 21, word-address width driven to the controller; sweep covers 2^(ADDR_BITS+1) bytes.
- INIT_SLOTS, 40, clkref periods to wait after reset before the first access; covers controller init of 32 x 14 clk.
- SAMPLE_PHASE, 7, clk count after the detected clkref rise at which read data is sampled.
- PHASE_BITS, 4, width of the slot phase counter.

Ports:
- clk  in  1  SDRAM clock, 14 x clkref rate
- init_n  in  1  asynchronous active-low reset
- clkref  in  1  14 MHz reference, same signal the controller syncs to
- start  in  1  pulse; begins a full test when idle
- addr  out  ADDR_BITS  word address to controller
- aux  out  1  byte select: 0 = low byte, 1 = high byte
- din  out  8  write data
- we  out  1  write request
- dout  in  16  read data from controller
- busy  out  1  test in progress
- done  out  1  test finished, held until next start
- pass  out  1  valid with done; 1 = zero errors
- err_count  out  16  saturating mismatch count
- err_addr  out  ADDR_BITS+1  byte address {addr,aux} of the first mismatch
- err_exp  out  8  expected byte at the first mismatch
- err_got  out  8  read byte at the first mismatch

Behaviour:
- Reset (init_n low, async): addr=0, aux=0, din=0, we=0, busy=0, done=0, pass=0, err_count=0, err_addr=0, err_exp=0, err_got=0, state=S_INIT, slot counter=0.
- Slot timing:
  - clkref is registered once; a rise is detected as clkref_q & ~clkref_qq.
  - The phase counter clears to 0 on the detect cycle and saturates at its maximum.
  - addr/aux/din/we update only on the detect cycle and hold for the full slot.
- Byte counter bc has width ADDR_BITS+1: aux = bc[0], addr = bc[ADDR_BITS:1].
- Patterns p = 0..3, with A = bc:
  - p0: 0x55
  - p1: 0xAA
  - p2: A[7:0] ^ A[15:8] ^ zero-extended upper bits
  - p3: ~(p2 value)
- State machine, advancing only on slot boundaries:
  - S_INIT: counts INIT_SLOTS slots with we=0, then goes to S_IDLE. A start received during S_INIT is remembered and acted on at S_IDLE entry.
  - S_IDLE: on start, clears err_*, done, pass and sets busy=1, p=0, bc=0, then goes to S_WR.
  - S_WR: we=1, din=pattern(p,bc). After the slot with bc=max, bc wraps to 0 and the block goes to S_RD.
  - S_RD: we=0.
    - At phase == SAMPLE_PHASE it compares dout[7:0] (aux=0) or dout[15:8] (aux=1) against pattern(p,bc).
    - On mismatch err_count increments, saturating at 0xFFFF.
    - The first mismatch since start latches err_addr, err_exp and err_got.
    - After bc=max: if p=3 go to S_DONE, else p+1 and S_WR.
  - S_DONE: busy=0, done=1, pass=(err_count==0), we=0. A new start behaves as from S_IDLE.
- Start while busy is ignored.
- Reset mid-test aborts immediately to S_INIT and re-waits INIT_SLOTS. The controller is reset by the same init_n.
- Only one sample per read slot. If clkref stops, the phase saturates and no further sample is taken.

Optional Feature:
- SDRAM_TEST_STOP_ON_ERR_EN defined: the first mismatch ends the test.
  - At the next slot boundary the block enters S_DONE with pass=0, err_count=1 and err_* latched.
  - Remaining addresses and patterns are skipped.
- Undefined: the test always completes all four passes over all addresses, counting every mismatch.

Test Plan:
- ADDR_BITS=3, controller plus ideal SDRAM model, start after init -> busy within 1 slot; 4x(16 write + 16 read) = 128 slots; then done=1, pass=1, err_count=0.
- Same setup, model forces byte address 5 bit0 stuck-at-1 -> p0 expects 0x55 and reads 0x55 (no error); p1 expects 0xAA and gets 0xAB, so err_addr=5, err_exp=0xAA, err_got=0xAB; done with pass=0, err_count>=1.
- Repeat the stuck-bit run with SDRAM_TEST_STOP_ON_ERR_EN -> done asserted one slot after the p1 read of address 5; err_count=1.
- Assert start during S_INIT, then again while busy -> exactly one test runs; the second start is ignored; total slots unchanged.
- Drop init_n during a p2 S_WR slot -> all outputs return to reset values asynchronously; after release no access for 40 slots; a new start runs a clean pass.
- Check aux/byte-lane routing: on read of an odd byte address, the compare uses only dout[15:8], and a corrupted dout[7:0] produces no error.

Source files
------------

// File: rtl/sdram_test_seq.sv
// Slot-paced write/readback traffic generator and checker for the Apple II SDRAM controller.
// Build option: define SDRAM_TEST_STOP_ON_ERR_EN to end the test at the first mismatch.
`timescale 1ns/1ps
module sdram_test_seq #(
    parameter int ADDR_BITS    = 21,
    parameter int INIT_SLOTS   = 40,
    parameter int SAMPLE_PHASE = 7,
    parameter int PHASE_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 clkref,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 aux,
    output logic [7:0]           din,
    output logic                 we,
    input  logic [15:0]          dout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [ADDR_BITS:0]   err_addr,
    output logic [7:0]           err_exp,
    output logic [7:0]           err_got
);

    localparam int BC_W   = ADDR_BITS + 1;
    localparam int SLOT_W = $clog2(INIT_SLOTS + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_DONE} state_t;

    state_t                state;
    logic                  clkref_q;
    logic                  clkref_qq;
    logic                  rise;
    logic [PHASE_BITS-1:0] phase;
    logic [SLOT_W-1:0]     slot_cnt;
    logic [BC_W-1:0]       bc;
    logic [1:0]            p;
    logic                  start_pend;
    logic                  rd_slot;
    logic [7:0]            exp_byte;
    logic [7:0]            rd_byte;
    logic                  bc_last;
    logic                  mismatch;

    function automatic logic [7:0] pattern(input logic [1:0] pp, input logic [BC_W-1:0] a);
        logic [31:0] ax;
        logic [7:0]  mix;
        ax  = 32'(a);
        mix = ax[7:0] ^ ax[15:8] ^ ax[23:16] ^ ax[31:24];
        case (pp)
            2'd0:    pattern = 8'h55;
            2'd1:    pattern = 8'hAA;
            2'd2:    pattern = mix;
            default: pattern = ~mix;
        endcase
    endfunction

    assign rise     = clkref_q & ~clkref_qq;
    assign rd_byte  = aux ? dout[15:8] : dout[7:0];
    assign bc_last  = (bc == '1);
    // One sample per read slot; a stalled clkref parks phase at its maximum so no resample occurs.
    assign mismatch = rd_slot && !rise && (phase == PHASE_BITS'(SAMPLE_PHASE)) && (rd_byte != exp_byte);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= S_INIT;
            clkref_q   <= 1'b0;
            clkref_qq  <= 1'b0;
            phase      <= '0;
            slot_cnt   <= '0;
            bc         <= '0;
            p          <= 2'd0;
            start_pend <= 1'b0;
            rd_slot    <= 1'b0;
            exp_byte   <= 8'd0;
            addr       <= '0;
            aux        <= 1'b0;
            din        <= 8'd0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            err_addr   <= '0;
            err_exp    <= 8'd0;
            err_got    <= 8'd0;
        end else begin
            clkref_q  <= clkref;
            clkref_qq <= clkref_q;
            if (rise)
                phase <= '0;
            else if (phase != '1)
                phase <= phase + PHASE_BITS'(1);

            if (start && !busy)
                start_pend <= 1'b1;

            if (rise) begin
                case (state)
                    S_INIT: begin
                        we <= 1'b0;
                        if (slot_cnt == SLOT_W'(INIT_SLOTS - 1))
                            state <= S_IDLE;
                        else
                            slot_cnt <= slot_cnt + SLOT_W'(1);
                    end
                    S_IDLE, S_DONE: begin
                        we      <= 1'b0;
                        rd_slot <= 1'b0;
                        if (state == S_DONE) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_count == 16'd0);
                        end
                        if (start_pend) begin
                            start_pend <= 1'b0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            pass       <= 1'b0;
                            err_count  <= 16'd0;
                            err_addr   <= '0;
                            err_exp    <= 8'd0;
                            err_got    <= 8'd0;
                            p          <= 2'd0;
                            bc         <= '0;
                            state      <= S_WR;
                        end
                    end
                    S_WR, S_RD: begin
`ifdef SDRAM_TEST_STOP_ON_ERR_EN
                        if (err_count != 16'd0) begin
                            we      <= 1'b0;
                            rd_slot <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b0;
                            state   <= S_DONE;
                        end else
`endif
                        begin
                            addr <= bc[BC_W-1:1];
                            aux  <= bc[0];
                            bc   <= bc + BC_W'(1);
                            if (state == S_WR) begin
                                din     <= pattern(p, bc);
                                we      <= 1'b1;
                                rd_slot <= 1'b0;
                                if (bc_last)
                                    state <= S_RD;
                            end else begin
                                we       <= 1'b0;
                                rd_slot  <= 1'b1;
                                exp_byte <= pattern(p, bc);
                                // Done is declared one boundary later, after this slot's sample.
                                if (bc_last) begin
                                    if (p == 2'd3) begin
                                        state <= S_DONE;
                                    end else begin
                                        p     <= p + 2'd1;
                                        state <= S_WR;
                                    end
                                end
                            end
                        end
                    end
                    default: state <= S_INIT;
                endcase
            end else if (mismatch) begin
                if (err_count == 16'd0) begin
                    err_addr <= {addr, aux};
                    err_exp  <= exp_byte;
                    err_got  <= rd_byte;
                end
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_test_seq.sv
// Bench for sdram_test_seq with a small ideal SDRAM model, fault injection and a done-result scoreboard.
`timescale 1ns/1ps
module tb_sdram_test_seq;

    localparam int AB = 3;
    localparam int EW = 37;

    logic          clk = 1'b0;
    logic          init_n = 1'b0;
    logic          clkref = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] addr;
    logic          aux;
    logic [7:0]    din;
    logic          we;
    logic [15:0]   dout;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AB:0]   err_addr;
    logic [7:0]    err_exp, err_got;

    int total = 0;
    int bad   = 0;
    int wr_run = 0;
    int slots_since_rst = 0;
    int fault_mode = 0;
    logic done_prev = 1'b0;
    logic [EW-1:0] exp_q[$];

    logic [7:0] mem_lo[8];
    logic [7:0] mem_hi[8];

    sdram_test_seq #(.ADDR_BITS(AB), .INIT_SLOTS(40), .SAMPLE_PHASE(7), .PHASE_BITS(4)) dut (
        .clk(clk), .init_n(init_n), .clkref(clkref), .start(start),
        .addr(addr), .aux(aux), .din(din), .we(we), .dout(dout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
    );

    // clock/reset block: clk at 100 MHz, clkref at clk/14
    initial forever #5 clk = ~clk;
    initial forever begin
        clkref = 1'b1; #70;
        clkref = 1'b0; #70;
    end

    // ideal SDRAM: byte-lane writes, combinational read, optional read faults
    initial begin
        for (int i = 0; i < 8; i++) begin
            mem_lo[i] = 8'h00;
            mem_hi[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (init_n && we) begin
            if (aux) mem_hi[addr] <= din;
            else     mem_lo[addr] <= din;
        end
    end

    always_comb begin
        logic [7:0] lo, hi;
        lo = mem_lo[addr];
        hi = mem_hi[addr];
        if (fault_mode == 1 && addr == 3'd2) hi[0] = 1'b1;
        if (fault_mode == 2) begin
            if (aux) lo = ~lo;
            else     hi = ~hi;
        end
        dout = {hi, lo};
    end

    function automatic logic [7:0] tb_pat(input int pp, input logic [3:0] a);
        case (pp)
            0:       tb_pat = 8'h55;
            1:       tb_pat = 8'hAA;
            2:       tb_pat = {4'h0, a};
            default: tb_pat = ~{4'h0, a};
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // mid-slot monitor: no access during init wait, write sweep order and data
    always @(negedge clkref) begin
        if (!init_n) begin
            slots_since_rst = 0;
        end else begin
            if (slots_since_rst < 40) begin
                total++;
                if (we) begin
                    bad++;
                    $display("FAIL init_quiet: we=1 expected 0 in slot %0d after reset", slots_since_rst);
                end
            end
            slots_since_rst++;
            if (we) begin
                chk("wr_addr", int'({addr, aux}), wr_run % 16);
                chk("wr_data", int'(din), int'(tb_pat(wr_run / 16, 4'(wr_run % 16))));
                wr_run++;
            end
        end
    end

    // scoreboard monitor: each done rise pops one expected result
    always @(negedge clk) begin
        if (!init_n) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done rose with empty expected queue");
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("pass", int'(pass), int'(e[36]));
                    chk("err_count", int'(err_count), int'(e[35:20]));
                    chk("err_addr", int'(err_addr), int'(e[19:16]));
                    chk("err_exp", int'(err_exp), int'(e[15:8]));
                    chk("err_got", int'(err_got), int'(e[7:0]));
                end
            end
            done_prev <= done;
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_busy(input int max_clk);
        for (int i = 0; i < max_clk && !busy; i++) @(negedge clk);
        chk("busy_timeout", int'(busy), 1);
    endtask

    task automatic wait_done(input int max_clk);
        for (int i = 0; i < max_clk && !done; i++) @(negedge clk);
        chk("done_timeout", int'(done), 1);
    endtask

    task automatic run_test(input logic [EW-1:0] expv, input int exp_wr);
        wr_run = 0;
        exp_q.push_back(expv);
        pulse_start();
        wait_busy(3 * 14);
        wait_done(140 * 14);
        repeat (2) @(negedge clk);
        chk("write_slots", wr_run, exp_wr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, int'(addr), 0);
        chk({tag, "_aux"}, int'(aux), 0);
        chk({tag, "_din"}, int'(din), 0);
        chk({tag, "_we"}, int'(we), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_err_addr"}, int'(err_addr), 0);
        chk({tag, "_err_exp"}, int'(err_exp), 0);
        chk({tag, "_err_got"}, int'(err_got), 0);
    endtask

    initial begin
        int stuck_cnt;
        int stuck_wr;
`ifdef SDRAM_TEST_STOP_ON_ERR_EN
        stuck_cnt = 1;
        stuck_wr  = 32;
`else
        stuck_cnt = 2;
        stuck_wr  = 64;
`endif
        repeat (4) @(negedge clk);
        chk_reset_outputs("reset");
        init_n = 1'b1;

        // start during init is remembered; a second start while busy is ignored
        repeat (5 * 14) @(negedge clk);
        wr_run = 0;
        exp_q.push_back({1'b1, 16'd0, 4'd0, 8'h00, 8'h00});
        pulse_start();
        chk("busy_during_init", int'(busy), 0);
        wait_busy(45 * 14);
        repeat (20 * 14) @(negedge clk);
        pulse_start();
        wait_done(140 * 14);
        repeat (5 * 14) @(negedge clk);
        chk("single_run_writes", wr_run, 64);
        chk("no_second_run_busy", int'(busy), 0);
        chk("done_held", int'(done), 1);

        // stuck-at-1 on bit0 of byte address 5: p1 and p3 reads fail
        fault_mode = 1;
        run_test({1'b0, 16'(stuck_cnt), 4'd5, 8'hAA, 8'hAB}, stuck_wr);

        // inverted opposite byte lane must be ignored by the compare
        fault_mode = 2;
        run_test({1'b1, 16'd0, 4'd0, 8'h00, 8'h00}, 64);

        // reset during a p2 write slot aborts asynchronously
        fault_mode = 0;
        wr_run = 0;
        pulse_start();
        wait_busy(3 * 14);
        for (int i = 0; i < 100 * 14 && wr_run < 34; i++) @(negedge clk);
        chk("abort_in_p2_write", int'(wr_run >= 34 && we), 1);
        #2 init_n = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        init_n = 1'b1;
        repeat (42 * 14) @(negedge clk);
        run_test({1'b1, 16'd0, 4'd0, 8'h00, 8'h00}, 64);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
